// File: rtl/triangle_pkg.sv
// triangle_pkg: orientation constants and FSM encoding shared by the orientation controller and the triangle renderer.
package triangle_pkg;
    localparam int ORIENT_W = 5;
    localparam int D180 = 12;
    localparam int D360 = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        ROTATE = 2'd2
    } state_t;

    // Requests of 24..31 fold back into the 0..23 range.
    function automatic logic [ORIENT_W-1:0] wrap_orient(input logic [ORIENT_W-1:0] o);
        return (o >= ORIENT_W'(D360)) ? o - ORIENT_W'(D360) : o;
    endfunction
endpackage

// File: rtl/triangle_orient_ctrl_if.sv
// triangle_orient_ctrl_if: target handshake, frame tick and registered renderer outputs.
interface triangle_orient_ctrl_if;
    import triangle_pkg::*;
    logic                       frame_tick;
    logic                       tgt_valid;
    logic                       tgt_ready;
    logic signed [11:0]         tgt_x;
    logic signed [11:0]         tgt_y;
    logic        [ORIENT_W-1:0] tgt_orient;
    logic signed [11:0]         center_x;
    logic signed [11:0]         center_y;
    logic        [ORIENT_W-1:0] orientation;
    logic                       busy;
    logic                       done;

    modport master (
        output frame_tick, tgt_valid, tgt_x, tgt_y, tgt_orient,
        input  tgt_ready, center_x, center_y, orientation, busy, done
    );
    modport slave (
        input  frame_tick, tgt_valid, tgt_x, tgt_y, tgt_orient,
        output tgt_ready, center_x, center_y, orientation, busy, done
    );
endinterface

// File: rtl/orient_step.sv
// orient_step: one 15-degree step from cur toward tgt along the shorter arc (ties go +1), with wrap.
module orient_step
    import triangle_pkg::*;
(
    input  logic [ORIENT_W-1:0] cur_i,
    input  logic [ORIENT_W-1:0] tgt_i,
    output logic [ORIENT_W-1:0] nxt_o,
    output logic                at_target_o
);
    localparam logic [ORIENT_W-1:0] LAST = ORIENT_W'(D360 - 1);

    logic [ORIENT_W:0] d;
    logic              up;

    assign d = (tgt_i >= cur_i) ? {1'b0, tgt_i} - {1'b0, cur_i}
                                : {1'b0, tgt_i} + (ORIENT_W+1)'(D360) - {1'b0, cur_i};
    assign up = d <= (ORIENT_W+1)'(D180);
    assign at_target_o = cur_i == tgt_i;
    assign nxt_o = at_target_o ? cur_i
                 : up          ? ((cur_i == LAST) ? '0 : cur_i + 1'b1)
                               : ((cur_i == '0) ? LAST : cur_i - 1'b1);
endmodule

// File: rtl/triangle_orient_ctrl.sv
// triangle_orient_ctrl: accepts sprite targets, commits center on a frame tick, then steps orientation
// once every STEP_FRAMES frames; every output is a register so changes land only after a frame tick.
module triangle_orient_ctrl
    import triangle_pkg::*;
#(
    parameter int                 STEP_FRAMES = 4,
    parameter logic signed [11:0] HOME_X      = 12'sd512,
    parameter logic signed [11:0] HOME_Y      = 12'sd384
) (
    input  logic                   clock,
    input  logic                   reset_n,
    triangle_orient_ctrl_if.slave  bus
);
    state_t                    state_q, state_d;
    logic signed [11:0]        cx_q, cx_d, cy_q, cy_d, px_q, px_d, py_q, py_d;
    logic        [ORIENT_W-1:0] orient_q, orient_d, pt_q, pt_d, step_nxt;
    logic        [7:0]          cnt_q, cnt_d;
    logic                       done_q, done_d, busy_q, busy_d, ready_q, ready_d;
    logic                       at_tgt, accept, step_now;

    orient_step u_step (
        .cur_i      (orient_q),
        .tgt_i      (pt_q),
        .nxt_o      (step_nxt),
        .at_target_o(at_tgt)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cx_q     <= HOME_X;
            cy_q     <= HOME_Y;
            px_q     <= '0;
            py_q     <= '0;
            pt_q     <= '0;
            orient_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            px_q     <= px_d;
            py_q     <= py_d;
            pt_q     <= pt_d;
            orient_q <= orient_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
        end
    end

    assign accept   = bus.tgt_valid && ready_q;
    assign step_now = bus.frame_tick && (cnt_q == 8'(STEP_FRAMES - 1));

    always_comb begin
        state_d  = state_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        px_d     = px_q;
        py_d     = py_q;
        pt_d     = pt_q;
        orient_d = orient_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        case (state_q)
            COMMIT: if (bus.frame_tick) begin
                cx_d    = px_q;
                cy_d    = py_q;
                cnt_d   = '0;
                state_d = at_tgt ? IDLE : ROTATE;
                done_d  = at_tgt;
            end
            ROTATE: if (bus.frame_tick) begin
                cnt_d = step_now ? 8'd0 : cnt_q + 8'd1;
                if (step_now) begin
                    orient_d = step_nxt;
                    state_d  = (step_nxt == pt_q) ? IDLE : ROTATE;
                    done_d   = step_nxt == pt_q;
                end
            end
            IDLE:    ;
            default: state_d = IDLE;
        endcase
        // A new target overrides any finish this cycle; a coinciding step still used the old target.
        if (accept) begin
            px_d    = bus.tgt_x;
            py_d    = bus.tgt_y;
            pt_d    = wrap_orient(bus.tgt_orient);
            state_d = COMMIT;
            done_d  = 1'b0;
        end
        busy_d  = state_d != IDLE;
        ready_d = state_d != COMMIT;
    end

    assign bus.tgt_ready   = ready_q;
    assign bus.center_x    = cx_q;
    assign bus.center_y    = cy_q;
    assign bus.orientation = orient_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_triangle_orient_ctrl.sv
// tb_triangle_orient_ctrl: directed scenarios plus random traffic on two instances (STEP_FRAMES 1 and 3),
// compared every cycle against a frame-level reference model.
module tb_triangle_orient_ctrl;
    import triangle_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    triangle_orient_ctrl_if ifc0 ();
    triangle_orient_ctrl_if ifc1 ();

    triangle_orient_ctrl #(.STEP_FRAMES(1)) dut0 (.clock(clock), .reset_n(reset_n), .bus(ifc0.slave));
    triangle_orient_ctrl #(.STEP_FRAMES(3)) dut1 (.clock(clock), .reset_n(reset_n), .bus(ifc1.slave));

    always #5 clock = ~clock;

    localparam logic [31:0] RST_W = {1'b1, 1'b0, 1'b0, 5'd0, 12'd512, 12'd384};

    int n_checks = 0;
    int n_errors = 0;
    int dones = 0;
    int sf[2] = '{1, 3};
    int m_ph[2], m_o[2], m_cx[2], m_cy[2], m_px[2], m_py[2], m_pt[2], m_cnt[2], m_done[2];
    logic [31:0] obs[2];

    assign obs[0] = {ifc0.tgt_ready, ifc0.busy, ifc0.done, ifc0.orientation, ifc0.center_x, ifc0.center_y};
    assign obs[1] = {ifc1.tgt_ready, ifc1.busy, ifc1.done, ifc1.orientation, ifc1.center_x, ifc1.center_y};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // m_ph: 0 idle, 1 waiting for commit tick, 2 rotating
    function automatic logic [31:0] exp_word(input int k);
        return {m_ph[k] != 1, m_ph[k] != 0, m_done[k] != 0, 5'(m_o[k]), 12'(m_cx[k]), 12'(m_cy[k])};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ph[k] = 0; m_o[k] = 0; m_cx[k] = 512; m_cy[k] = 384;
            m_px[k] = 0; m_py[k] = 0; m_pt[k] = 0; m_cnt[k] = 0; m_done[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input bit tick, input bit valid, input int x, input int y, input int o);
        bit acc = valid && m_ph[k] != 1;
        int d;
        m_done[k] = 0;
        if (tick && m_ph[k] == 1) begin
            m_cx[k] = m_px[k]; m_cy[k] = m_py[k]; m_cnt[k] = 0;
            if (m_o[k] == m_pt[k]) begin m_ph[k] = 0; m_done[k] = 1; end
            else m_ph[k] = 2;
        end else if (tick && m_ph[k] == 2) begin
            if (m_cnt[k] == sf[k] - 1) begin
                m_cnt[k] = 0;
                d = ((m_pt[k] - m_o[k]) % 24 + 24) % 24;
                m_o[k] = (m_o[k] + ((d <= 12) ? 1 : 23)) % 24;
                if (m_o[k] == m_pt[k] && !acc) begin m_ph[k] = 0; m_done[k] = 1; end
            end else m_cnt[k]++;
        end
        if (acc) begin
            m_px[k] = x; m_py[k] = y; m_pt[k] = o % 24; m_ph[k] = 1;
        end
    endtask

    task automatic cycle(input bit tick, input bit valid = 0, input int x = 0, input int y = 0, input int o = 0);
        ifc0.frame_tick = tick; ifc1.frame_tick = tick;
        ifc0.tgt_valid = valid; ifc1.tgt_valid = valid;
        ifc0.tgt_x = 12'(x); ifc1.tgt_x = 12'(x);
        ifc0.tgt_y = 12'(y); ifc1.tgt_y = 12'(y);
        ifc0.tgt_orient = 5'(o); ifc1.tgt_orient = 5'(o);
        @(posedge clock);
        for (int k = 0; k < 2; k++) model_step(k, tick, valid, x, y, o);
        #1;
        chk("outs0", obs[0], exp_word(0));
        chk("outs1", obs[1], exp_word(1));
        if (ifc0.done) dones++;
    endtask

    task automatic offer(input int x, input int y, input int o);
        cycle(0, 1, x, y, o);
    endtask

    task automatic frame();
        cycle(1);
        repeat (9) cycle(0);
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        chk("arst0", obs[0], RST_W);
        chk("arst1", obs[1], RST_W);
        model_reset();
        @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        int d0;
        model_reset();
        ifc0.frame_tick = 0; ifc1.frame_tick = 0;
        ifc0.tgt_valid = 0; ifc1.tgt_valid = 0;
        ifc0.tgt_x = 0; ifc1.tgt_x = 0; ifc0.tgt_y = 0; ifc1.tgt_y = 0;
        ifc0.tgt_orient = 0; ifc1.tgt_orient = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset", obs[0], RST_W);
        reset_n = 1'b1;
        // basic rotate
        offer(100, -50, 3);
        frame();
        chk("r34_cx", ifc0.center_x, 100);
        chk("r34_cy", ifc0.center_y, -50);
        chk("r34_o0", ifc0.orientation, 0);
        for (int i = 1; i <= 3; i++) begin
            frame();
            chk("r34_o", ifc0.orientation, i);
        end
        chk("r34_done", dones, 1);
        chk("r34_busy", ifc0.busy, 0);
        // wrap via shortest path
        offer(0, 0, 1);
        repeat (3) frame();
        chk("r35_start", ifc0.orientation, 1);
        d0 = dones;
        offer(0, 0, 22);
        frame();
        chk("r35_commit", ifc0.orientation, 1);
        frame(); chk("r35_a", ifc0.orientation, 0);
        frame(); chk("r35_b", ifc0.orientation, 23);
        frame(); chk("r35_c", ifc0.orientation, 22);
        chk("r35_done", dones, d0 + 1);
        // tie goes +1
        offer(0, 0, 0);
        repeat (3) frame();
        chk("r36_start", ifc0.orientation, 0);
        offer(0, 0, 12);
        frame();
        for (int i = 1; i <= 12; i++) begin
            frame();
            chk("r36_o", ifc0.orientation, i);
        end
        // retarget mid-rotation
        offer(0, 0, 0);
        repeat (14) frame();
        chk("r37_start", ifc0.orientation, 0);
        offer(0, 0, 6);
        repeat (4) frame();
        chk("r37_mid", ifc0.orientation, 3);
        d0 = dones;
        offer(0, 0, 0);
        chk("r37_hold", ifc0.orientation, 3);
        frame();
        chk("r37_commit", ifc0.orientation, 3);
        for (int i = 2; i >= 0; i--) begin
            frame();
            chk("r37_o", ifc0.orientation, i);
        end
        chk("r37_done", dones, d0 + 1);
        // folded target with a tick in the acceptance cycle
        cycle(1, 1, 7, 8, 26);
        chk("r38_busy", ifc0.busy, 1);
        chk("r38_nocommit", ifc0.center_x, 0);
        frame();
        chk("r38_cx", ifc0.center_x, 7);
        repeat (2) frame();
        chk("r38_o", ifc0.orientation, 2);
        chk("r38_idle", ifc0.busy, 0);
        // async reset mid-rotation
        offer(0, 0, 10);
        repeat (4) frame();
        chk("r39_pre", ifc0.orientation, 5);
        d0 = dones;
        do_reset();
        cycle(0);
        chk("r39_ready", ifc0.tgt_ready, 1);
        chk("r39_nodone", dones, d0);
        // random traffic
        repeat (4000) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            else cycle($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                       int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
                       int'($urandom_range(0, 31)));
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/triangle_orient_ctrl.md
TRIANGLE_ORIENT_CTRL -- requirements
Module: triangle_orient_ctrl

Interface
REQ-001 Parameter STEP_FRAMES, default 4, frames between successive 15-degree orientation steps (range 1..255).
REQ-002 Parameter HOME_X, default 12'sd512, center_x reset value.
REQ-003 Parameter HOME_Y, default 12'sd384, center_y reset value.
REQ-004 clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 frame_tick  input  1  one-cycle pulse at the start of vertical blanking.
REQ-007 tgt_valid  input  1  new target offered.
REQ-008 tgt_ready  output  1  target accepted when tgt_valid && tgt_ready.
REQ-009 tgt_x, tgt_y  input  12 each, signed  requested sprite center.
REQ-010 tgt_orient  input  5  requested orientation in 15-degree units.
REQ-011 center_x, center_y  output  12 each, signed  registered center to the triangle renderer.
REQ-012 orientation  output  5  registered orientation to the renderer, always 0..23.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 done  output  1  one-cycle pulse when the displayed orientation reaches the target.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, COMMIT and ROTATE.
REQ-016 tgt_ready SHALL be high in IDLE and ROTATE and low in COMMIT.
REQ-017 On acceptance, the block SHALL latch tgt_x, tgt_y and tgt_orient into pending registers and enter COMMIT (from either IDLE or ROTATE).
REQ-018 A tgt_orient value of 24..31 SHALL be latched as tgt_orient-24.
REQ-019 On the first frame_tick in COMMIT, center_x/center_y SHALL take the pending values and the frame counter SHALL clear; a frame_tick in the same cycle as acceptance SHALL NOT commit.
REQ-020 The COMMIT exit SHALL go to IDLE with a done pulse on the next cycle if orientation equals the target, otherwise to ROTATE.
REQ-021 Outputs SHALL change only in the cycle after a frame_tick, so the renderer never sees a mid-frame change.
REQ-022 In ROTATE, the frame counter SHALL increment on each frame_tick; on the frame_tick where it equals STEP_FRAMES-1, it SHALL clear and orientation SHALL step once.
REQ-023 Step direction: d = (target - orientation) mod 24; d in 1..12 gives +1, d in 13..23 gives -1 (a tie at 12 goes +1).
REQ-024 Wrap-around: 23+1 SHALL give 0 and 0-1 SHALL give 23.
REQ-025 When a step makes orientation equal the target, the block SHALL pulse done in the cycle after the step and enter IDLE.
REQ-026 A retarget accepted in ROTATE SHALL NOT change orientation until commit; rotation then resumes toward the new target from the current orientation with a fresh counter.
REQ-027 If acceptance and a step-eligible frame_tick coincide in ROTATE, the step SHALL be taken toward the old target and the new target latched; acceptance wins the state transition.
REQ-028 frame_tick in IDLE SHALL have no effect.

Reset
REQ-029 While reset_n is low, the block SHALL hold: state IDLE, center_x=HOME_X, center_y=HOME_Y, orientation=0, pending target=0, frame counter=0, busy=0, done=0.
REQ-030 Reset asserted mid-rotation SHALL abandon the pending target; after release, tgt_ready SHALL be high in the first cycle.

Structure
REQ-031 Package triangle_pkg SHALL hold ORIENT_W=5, D180=12, D360=24, and the FSM state encoding, shared with the triangle renderer.
REQ-032 Combinational sub-module orient_step SHALL take current and target orientation and return the next orientation (direction plus wrap) and an at_target flag.
REQ-033 All outputs SHALL be driven directly from registers.

Verification
REQ-034 Reset/basic rotate: release reset; offer target (100,-50,3); ticks every 10 cycles with STEP_FRAMES=1 -> center=(100,-50) after tick 1; orientation 1,2,3 after ticks 2..4; done once.
REQ-035 Wrap, shortest path: orientation 1, target 22 -> sequence 0,23,22; done after the third step.
REQ-036 Tie case: orientation 0, target 12 -> increments 1..12 (+1 direction), 12 steps.
REQ-037 Retarget mid-rotation: orientation 0 rotating toward 6; at orientation 3 offer target 0 -> orientation holds 3 until commit tick, then 2,1,0; done exactly once.
REQ-038 Boundary: tgt_orient=26 with frame_tick in the acceptance cycle -> no commit that cycle; latched target is 2.
REQ-039 Async reset asserted at orientation 5 while rotating -> orientation=0, center=(HOME_X,HOME_Y), busy=0 immediately, no done pulse.
